// File: rtl/synth_pkg.sv
// Shared types and helpers for the stereo echo datapath: FSM state encoding
// and a width-generic signed saturator.
package synth_pkg;

   typedef enum logic [2:0] {
      CLEAR = 3'd0,
      IDLE  = 3'd1,
      RD    = 3'd2,
      LAT   = 3'd3,
      WR    = 3'd4,
      OUT   = 3'd5
   } state_t;

   localparam int unsigned SAT_W = 64;

   // Clamp a sign-extended sum to the signed range of a width-bit sample.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] sum,
      input int unsigned             width
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
      lo = ~hi;
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM, single clock, two-stage registered read path.
module sdp_bram #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned DEPTH      = 8192,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd_q  <= mem[raddr];
      rdata <= rd_q;
   end

endmodule

// File: rtl/stereo_echo.sv
// Multi-channel feedback echo: one delay line per channel in a shared RAM,
// channels processed serially through a single adder/saturator.
module stereo_echo
   import synth_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned NUM_CH     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
   input  logic [ADDR_WIDTH-1:0]        delay_len,
   input  logic [$clog2(DATA_WIDTH):0]  decay_shift,
   input  logic                         bypass,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] m_data
);

   localparam int unsigned SHIFT_W = $clog2(DATA_WIDTH) + 1;
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DEPTH   = NUM_CH << ADDR_WIDTH;
   localparam int unsigned RAM_AW  = $clog2(DEPTH);
   localparam int unsigned SUM_W   = DATA_WIDTH + 1;

   state_t                       state, state_nxt;
   logic [ADDR_WIDTH-1:0]        wp, wp_nxt;
   logic [CH_W-1:0]              ch, ch_nxt;
   logic [RAM_AW-1:0]            clr_addr, clr_nxt;
   logic [NUM_CH*DATA_WIDTH-1:0] cap_data, cap_data_nxt;
   logic [ADDR_WIDTH-1:0]        cap_delay, cap_delay_nxt;
   logic [SHIFT_W-1:0]           cap_shift, cap_shift_nxt;
   logic                         cap_bypass, cap_bypass_nxt;
   logic                         m_valid_nxt, s_ready_nxt;
   logic [NUM_CH*DATA_WIDTH-1:0] m_data_nxt;

   logic                         wr_en, ram_we;
   logic [RAM_AW-1:0]            ram_waddr, ram_raddr;
   logic [DATA_WIDTH-1:0]        ram_wdata;
   logic signed [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_WIDTH-1:0]        eff_delay, rd_ptr;
   logic signed [DATA_WIDTH-1:0] cur_x, y, fb;
   logic signed [SUM_W-1:0]      sum;

   sdp_bram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   // Zero delay would read the slot being written this frame; treat it as one.
   assign eff_delay = (cap_delay == '0) ? ADDR_WIDTH'(1) : cap_delay;
   assign rd_ptr    = wp - eff_delay;
   assign ram_raddr = RAM_AW'({ch, rd_ptr});
   assign ram_we    = wr_en & ~rst;

   always_comb begin
      cur_x = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (ch == CH_W'(c)) cur_x = cap_data[c*DATA_WIDTH +: DATA_WIDTH];
   end

   // Shared adder/saturator and feedback attenuation.
   always_comb begin
      sum = SUM_W'(cur_x) + SUM_W'(ram_q);
      y   = DATA_WIDTH'(saturate(SAT_W'(sum), DATA_WIDTH));
      if (cap_shift >= SHIFT_W'(DATA_WIDTH)) fb = {DATA_WIDTH{y[DATA_WIDTH-1]}};
      else                                   fb = y >>> cap_shift;
   end

   always_comb begin
      state_nxt      = state;
      wp_nxt         = wp;
      ch_nxt         = ch;
      clr_nxt        = clr_addr;
      cap_data_nxt   = cap_data;
      cap_delay_nxt  = cap_delay;
      cap_shift_nxt  = cap_shift;
      cap_bypass_nxt = cap_bypass;
      m_valid_nxt    = m_valid;
      m_data_nxt     = m_data;
      wr_en          = 1'b0;
      ram_waddr      = RAM_AW'({ch, wp});
      ram_wdata      = fb;

      case (state)
         CLEAR: begin
            wr_en     = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
            clr_nxt   = clr_addr + RAM_AW'(1);
            if (clr_addr == RAM_AW'(DEPTH - 1)) begin
               clr_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (s_valid && s_ready) begin
               cap_data_nxt   = s_data;
               cap_delay_nxt  = delay_len;
               cap_shift_nxt  = decay_shift;
               cap_bypass_nxt = bypass;
               ch_nxt         = '0;
               state_nxt      = RD;
            end
         end
         RD:  state_nxt = LAT;
         LAT: state_nxt = WR;
         WR: begin
            wr_en = 1'b1;
            for (int c = 0; c < NUM_CH; c++)
               if (ch == CH_W'(c))
                  m_data_nxt[c*DATA_WIDTH +: DATA_WIDTH] = cap_bypass ? cur_x : y;
            if (ch == CH_W'(NUM_CH - 1)) begin
               ch_nxt    = '0;
               state_nxt = OUT;
            end else begin
               ch_nxt    = ch + CH_W'(1);
               state_nxt = RD;
            end
         end
         OUT: begin
            if (m_valid && m_ready) begin
               m_valid_nxt = 1'b0;
               wp_nxt      = wp + ADDR_WIDTH'(1);
               state_nxt   = IDLE;
            end else begin
               m_valid_nxt = 1'b1;
            end
         end
         default: state_nxt = CLEAR;
      endcase

      s_ready_nxt = (state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         wp         <= '0;
         ch         <= '0;
         clr_addr   <= '0;
         cap_data   <= '0;
         cap_delay  <= '0;
         cap_shift  <= '0;
         cap_bypass <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         s_ready    <= 1'b0;
      end else begin
         state      <= state_nxt;
         wp         <= wp_nxt;
         ch         <= ch_nxt;
         clr_addr   <= clr_nxt;
         cap_data   <= cap_data_nxt;
         cap_delay  <= cap_delay_nxt;
         cap_shift  <= cap_shift_nxt;
         cap_bypass <= cap_bypass_nxt;
         m_valid    <= m_valid_nxt;
         m_data     <= m_data_nxt;
         s_ready    <= s_ready_nxt;
      end
   end

endmodule
